openframe_pad_ctrl: RTL

OPENFRAME_PAD_CTRL -- requirements
Module: openframe_pad_ctrl

---
 rtl/openframe_pad_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/openframe_pad_ctrl.sv
// Pad configuration controller: per-pad shadow/active config registers behind a
// simple request port, core function muxing onto pad drive, and input synchronisers.
module openframe_pad_ctrl #(
  parameter int NUM_PADS    = 44,
  parameter int NUM_FUNCS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          ext_clk,
  input  logic                          resetb_l,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic                          cfg_we,
  input  logic [5:0]                    cfg_addr,
  input  logic [7:0]                    cfg_wdata,
  output logic [7:0]                    cfg_rdata,
  output logic                          cfg_rvalid,
  output logic                          cfg_err,
  input  logic                          cfg_commit,
  input  logic                          freeze,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] func_out,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] func_oe,
  output logic [NUM_PADS-1:0]           func_in,
  input  logic [NUM_PADS-1:0]           pad_in,
  output logic [NUM_PADS-1:0]           pad_out,
  output logic [NUM_PADS-1:0]           pad_oeb,
  output logic [NUM_PADS-1:0]           pad_inp_dis,
  output logic [NUM_PADS-1:0]           pad_slow_sel,
  output logic [3*NUM_PADS-1:0]         pad_dm
);

  localparam int FW = $clog2(NUM_FUNCS);

  logic [7:0]          shadow [NUM_PADS];
  logic [7:0]          active [NUM_PADS];
  logic                pending;
  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] nxt_out, nxt_oeb, en_vec;

  logic       accept, addr_ok, wr_en, do_copy;
  logic [5:0] idx;

  assign cfg_ready = ~cfg_rvalid;
  assign accept    = cfg_valid & cfg_ready;
  assign addr_ok   = ({26'd0, cfg_addr} < 32'(NUM_PADS));
  // Clamp so out-of-range requests never index past the register arrays.
  assign idx       = addr_ok ? cfg_addr : 6'd0;
  assign wr_en     = accept & cfg_we & addr_ok & ~active[idx][7];
  assign do_copy   = ~freeze & (cfg_commit | pending);

  always_ff @(posedge ext_clk or negedge resetb_l) begin
    if (!resetb_l) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shadow[p] <= '0;
        active[p] <= '0;
      end
      pending    <= 1'b0;
      cfg_rvalid <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      pending <= freeze & (cfg_commit | pending);
      // Copy sees pre-edge shadows, so a write in the commit cycle waits for the next commit.
      if (do_copy) begin
        for (int p = 0; p < NUM_PADS; p++) active[p] <= shadow[p];
      end
      if (wr_en) shadow[idx] <= cfg_wdata;
      cfg_rvalid <= accept & ~cfg_we;
      cfg_err    <= accept & ~addr_ok;
      cfg_rdata  <= (accept & ~cfg_we & addr_ok) ? shadow[idx] : 8'd0;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_FUNCS-1:0] fo, foe;
    logic [FW-1:0]        sel;
    logic                 en;

    assign fo  = func_out[p*NUM_FUNCS +: NUM_FUNCS];
    assign foe = func_oe[p*NUM_FUNCS +: NUM_FUNCS];
    assign sel = active[p][FW-1:0];
    assign en  = active[p][6];

    assign nxt_out[p]         = en & fo[sel];
    assign nxt_oeb[p]         = ~(en & foe[sel]);
    assign en_vec[p]          = en;
    assign pad_dm[3*p +: 3]   = active[p][4:2];
    assign pad_slow_sel[p]    = active[p][5];
    assign pad_inp_dis[p]     = ~en;
  end

  always_ff @(posedge ext_clk or negedge resetb_l) begin
    if (!resetb_l) begin
      pad_out <= '0;
      pad_oeb <= '1;
    end else if (!freeze) begin
      pad_out <= nxt_out;
      pad_oeb <= nxt_oeb;
    end
  end

  always_ff @(posedge ext_clk or negedge resetb_l) begin
    if (!resetb_l) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign func_in = sync_q[SYNC_STAGES-1] & en_vec;

endmodule
